// File: rtl/cpu_rf_seq_pkg.sv
// Shared definitions for the single-read-port regfile initiator.
// Contents:
//   state_t : sequencer states (IDLE, ISS1, ISS2, CAP, RSP)
//   XLEN/AW : data and register-address widths
//   RF_X0   : hard-wired zero register address
//   is_oob  : out-of-bounds test for 16-register mode
package cpu_rf_seq_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;

  localparam logic [AW-1:0] RF_X0 = 5'd0;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ISS1 = 3'd1,
    ISS2 = 3'd2,
    CAP  = 3'd3,
    RSP  = 3'd4
  } state_t;

  // In 16-register mode, any address at or above 16 (bit 4 set) does not exist.
  function automatic logic is_oob(input logic [AW-1:0] addr, input logic half);
    return half & (addr > 5'd15);
  endfunction

endpackage

// File: rtl/cpu_rf_operand_slot.sv
// One operand holding slot of the regfile initiator.
// Ports:
//   clk, rst          : clock, synchronous active-low reset
//   load, load_addr   : new request accepted; latch address, clear data
//   issue             : this slot's read is being issued to the regfile
//   capture           : take this slot's operand this cycle
//   drop              : response consumed, stop snooping writes
//   rd_data           : regfile read data (valid the cycle after issue)
//   commit, wr_addr, wr_data : regfile write committed this cycle
//   addr, data        : held address and operand value
module cpu_rf_operand_slot
  import cpu_rf_seq_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [AW-1:0]   load_addr,
  input  logic            issue,
  input  logic            capture,
  input  logic            drop,
  input  logic [XLEN-1:0] rd_data,
  input  logic            commit,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  output logic [AW-1:0]   addr,
  output logic [XLEN-1:0] data
);

  logic [AW-1:0]   addr_q;
  logic [XLEN-1:0] data_q;
  logic            held_q;
  logic            fwd_pend_q;
  logic [XLEN-1:0] fwd_data_q;
  logic            hit;
  logic [XLEN-1:0] cap_val;

  // x0 is never forwarded; commits are already filtered for x0 upstream,
  // but the slot guards it locally as well.
  assign hit = commit & (wr_addr == addr_q) & (addr_q != RF_X0);

  // Capture mux: x0 -> 0, then a write in this very cycle, then a write that
  // collided with the issue cycle (regfile returned old data), then regfile.
  always_comb begin
    cap_val = rd_data;
    if (addr_q == RF_X0) begin
      cap_val = 32'd0;
    end else if (hit) begin
      cap_val = wr_data;
    end else if (fwd_pend_q) begin
      cap_val = fwd_data_q;
    end else begin
      cap_val = rd_data;
    end
  end

  // Slot state: address, operand, pending collision forward, held snoop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q     <= RF_X0;
      data_q     <= 32'd0;
      held_q     <= 1'b0;
      fwd_pend_q <= 1'b0;
      fwd_data_q <= 32'd0;
    end else if (load) begin
      addr_q     <= load_addr;
      data_q     <= 32'd0;
      held_q     <= 1'b0;
      fwd_pend_q <= 1'b0;
      fwd_data_q <= 32'd0;
    end else begin
      if (issue) begin
        fwd_pend_q <= hit;
        fwd_data_q <= wr_data;
      end
      if (capture) begin
        data_q     <= cap_val;
        held_q     <= 1'b1;
        fwd_pend_q <= 1'b0;
      end else if (held_q && hit) begin
        data_q <= wr_data;
      end
      if (drop) begin
        held_q <= 1'b0;
      end
    end
  end

  assign addr = addr_q;
  assign data = data_q;

endmodule

// File: rtl/cpu_regfile_port_seq.sv
// Initiator side of a single-read-port, synchronous-read register file.
// Fetches rs1 (and optionally rs2) through one read port with one-cycle
// latency, honours regfile busy, forwards committed writebacks into fetched
// operands and returns both operands through a valid/ready response.
// Ports:
//   i_clk, i_rst                  : clock, synchronous active-low reset
//   i_req_valid/o_req_ready       : operand fetch handshake
//   i_rs1_addr, i_rs2_addr, i_use_rs2 : request fields
//   o_rsp_valid/i_rsp_ready       : response handshake
//   o_rs1_data, o_rs2_data, o_rsp_oob : response fields
//   i_wb_valid/o_wb_ready, i_wb_addr, i_wb_data, o_wb_oob : writeback path
//   o_rf_rd_en, o_rf_rd_addr, i_rf_rd_data : regfile read port
//   o_rf_wr_en, o_rf_wr_addr, o_rf_wr_data : regfile write port
//   i_rf_busy                     : regfile refuses reads/writes this cycle
module cpu_regfile_port_seq
  import cpu_rf_seq_pkg::*;
#(
  parameter bit p_half_regfile = 1'b0
)
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [AW-1:0]   i_rs1_addr,
  input  logic [AW-1:0]   i_rs2_addr,
  input  logic            i_use_rs2,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [XLEN-1:0] o_rs1_data,
  output logic [XLEN-1:0] o_rs2_data,
  output logic            o_rsp_oob,
  input  logic            i_wb_valid,
  output logic            o_wb_ready,
  input  logic [AW-1:0]   i_wb_addr,
  input  logic [XLEN-1:0] i_wb_data,
  output logic            o_wb_oob,
  output logic            o_rf_rd_en,
  output logic [AW-1:0]   o_rf_rd_addr,
  input  logic [XLEN-1:0] i_rf_rd_data,
  output logic            o_rf_wr_en,
  output logic [AW-1:0]   o_rf_wr_addr,
  output logic [XLEN-1:0] o_rf_wr_data,
  input  logic            i_rf_busy
);

  state_t          state;
  state_t          state_nx;
  logic            use_rs2_q;
  logic            oob_q;
  logic            iss2_first_q;

  logic            req_ready;
  logic            rsp_valid;
  logic            rd_en;
  logic [AW-1:0]   rd_addr;
  logic            iss1;
  logic            iss2;
  logic            cap1;
  logic            cap2;
  logic            drop;

  logic            accept;
  logic            req_oob;
  logic            wb_take;
  logic            wb_is_oob;
  logic            commit;

  logic [AW-1:0]   rs1_addr_q;
  logic [AW-1:0]   rs2_addr_q;
  logic [XLEN-1:0] rs1_data_q;
  logic [XLEN-1:0] rs2_data_q;

  assign req_oob   = is_oob(i_rs1_addr, p_half_regfile)
                   | (i_use_rs2 & is_oob(i_rs2_addr, p_half_regfile));
  assign accept    = i_rst & i_req_valid & req_ready;

  // Writes are taken whenever the regfile is free; x0 and out-of-bounds
  // writes are accepted but never reach the regfile.
  assign wb_is_oob = is_oob(i_wb_addr, p_half_regfile);
  assign wb_take   = i_rst & i_wb_valid & ~i_rf_busy;
  assign commit    = wb_take & (i_wb_addr != RF_X0) & ~wb_is_oob;

  // Sequencer next state and per-state controls.
  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = RF_X0;
    iss1      = 1'b0;
    iss2      = 1'b0;
    cap1      = 1'b0;
    cap2      = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (i_req_valid) begin
          if (req_oob) begin
            state_nx = RSP;
          end else begin
            state_nx = ISS1;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      ISS1: begin
        rd_addr = rs1_addr_q;
        if (!i_rf_busy) begin
          rd_en = 1'b1;
          iss1  = 1'b1;
          if (use_rs2_q) begin
            state_nx = ISS2;
          end else begin
            state_nx = CAP;
          end
        end else begin
          state_nx = ISS1;
        end
      end
      ISS2: begin
        // rs1 data is only valid in the first ISS2 cycle; later busy
        // cycles must not overwrite it.
        cap1    = iss2_first_q;
        rd_addr = rs2_addr_q;
        if (!i_rf_busy) begin
          rd_en    = 1'b1;
          iss2     = 1'b1;
          state_nx = CAP;
        end else begin
          state_nx = ISS2;
        end
      end
      CAP: begin
        if (use_rs2_q) begin
          cap2 = 1'b1;
        end else begin
          cap1 = 1'b1;
        end
        state_nx = RSP;
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (i_rsp_ready) begin
          drop     = 1'b1;
          state_nx = IDLE;
        end else begin
          state_nx = RSP;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State register and latched request attributes.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state        <= IDLE;
      use_rs2_q    <= 1'b0;
      oob_q        <= 1'b0;
      iss2_first_q <= 1'b0;
    end else begin
      state        <= state_nx;
      iss2_first_q <= (state == ISS1) && (state_nx == ISS2);
      if (accept) begin
        use_rs2_q <= i_use_rs2;
        oob_q     <= req_oob;
      end
    end
  end

  cpu_rf_operand_slot u_slot_rs1 (
    .clk       (i_clk),
    .rst       (i_rst),
    .load      (accept),
    .load_addr (i_rs1_addr),
    .issue     (iss1),
    .capture   (cap1),
    .drop      (drop),
    .rd_data   (i_rf_rd_data),
    .commit    (commit),
    .wr_addr   (i_wb_addr),
    .wr_data   (i_wb_data),
    .addr      (rs1_addr_q),
    .data      (rs1_data_q)
  );

  cpu_rf_operand_slot u_slot_rs2 (
    .clk       (i_clk),
    .rst       (i_rst),
    .load      (accept),
    .load_addr (i_rs2_addr),
    .issue     (iss2),
    .capture   (cap2),
    .drop      (drop),
    .rd_data   (i_rf_rd_data),
    .commit    (commit),
    .wr_addr   (i_wb_addr),
    .wr_data   (i_wb_data),
    .addr      (rs2_addr_q),
    .data      (rs2_data_q)
  );

  // Every output is forced low while reset is asserted.
  assign o_req_ready  = i_rst & req_ready;
  assign o_rsp_valid  = i_rst & rsp_valid;
  assign o_rs1_data   = i_rst ? rs1_data_q : 32'd0;
  assign o_rs2_data   = i_rst ? rs2_data_q : 32'd0;
  assign o_rsp_oob    = i_rst & oob_q;
  assign o_rf_rd_en   = i_rst & rd_en;
  assign o_rf_rd_addr = i_rst ? rd_addr : RF_X0;
  assign o_wb_ready   = i_rst & ~i_rf_busy;
  assign o_wb_oob     = wb_take & wb_is_oob;
  assign o_rf_wr_en   = commit;
  assign o_rf_wr_addr = i_rst ? i_wb_addr : RF_X0;
  assign o_rf_wr_data = i_rst ? i_wb_data : 32'd0;

endmodule
